// File: rtl/me_scheduler_if.sv
// Bus between the motion-estimation sequencer and its SAD datapath.
// Handshake: there is no backpressure. pe_enable marks the cycle in which
// ref_data/search_data are valid and must be consumed; cand_done is a
// one-cycle pulse qualifying cand_x1/cand_x2/cand_y. start_signal is a level
// request whose rising edge starts a run; process_completed is held until
// start_signal is low again.
interface me_scheduler_if;
  logic       start_signal;
  logic [7:0] address_ref;
  logic [9:0] address_search1;
  logic [9:0] address_search2;
  logic       pe_enable;
  logic       acc_clear;
  logic       cand_done;
  logic [3:0] cand_x1;
  logic [3:0] cand_x2;
  logic [3:0] cand_y;
  logic       process_completed;
  logic [1:0] fsm_state;

  modport master (
    input  start_signal,
    output address_ref, address_search1, address_search2,
    output pe_enable, acc_clear, cand_done,
    output cand_x1, cand_x2, cand_y, process_completed, fsm_state
  );

  modport slave (
    output start_signal,
    input  address_ref, address_search1, address_search2,
    input  pe_enable, acc_clear, cand_done,
    input  cand_x1, cand_x2, cand_y, process_completed, fsm_state
  );
endinterface

// File: rtl/me_scheduler.sv
// Full-search block-matching sequencer: 16x16 block in a 32x32 window,
// two horizontally adjacent candidates per 256-cycle pass, 128 passes.
// fsm_state exposes the FSM encoding (0 IDLE, 1 RUN, 2 DRAIN, 3 DONE).
module me_scheduler (
  input logic           clk,
  input logic           rst,
  me_scheduler_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t     state;
  state_t     state_nx;
  logic       start_q;
  logic [7:0] pix;
  logic [6:0] cand;
  logic       drain_cnt;

  logic       start_edge;
  logic       issue;
  logic       last_issue;
  logic [4:0] row;
  logic [4:0] col;

  // Read-latency delay line: qualifiers and the pair tag follow the memory
  logic       pe_q;
  logic       clr_q;
  logic       last_q;
  logic [6:0] tag_q;
  logic       done_q;
  logic [3:0] x1_q;
  logic [3:0] x2_q;
  logic [3:0] y_q;

  assign start_edge = bus.start_signal & ~start_q;
  assign issue      = (state == RUN);
  assign last_issue = issue && (pix == 8'hFF) && (cand == 7'h7F);

  // Next-state logic; start edges outside IDLE are ignored
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start_edge) state_nx = RUN;
      RUN:     if (last_issue) state_nx = DRAIN;
      DRAIN:   if (drain_cnt) state_nx = DONE;
      DONE:    if (!bus.start_signal) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register, start-edge detector, pixel and candidate counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      start_q   <= 1'b0;
      pix       <= 8'd0;
      cand      <= 7'd0;
      drain_cnt <= 1'b0;
    end else begin
      state     <= state_nx;
      start_q   <= bus.start_signal;
      drain_cnt <= (state == DRAIN) && !drain_cnt;
      if (state == IDLE && start_edge) begin
        pix  <= 8'd0;
        cand <= 7'd0;
      end else if (issue) begin
        pix <= pix + 8'd1;
        if (pix == 8'hFF) cand <= cand + 7'd1;
      end
    end
  end

  // One-cycle delay matching the registered memory read, plus tag capture
  always_ff @(posedge clk) begin
    if (rst) begin
      pe_q   <= 1'b0;
      clr_q  <= 1'b0;
      last_q <= 1'b0;
      tag_q  <= 7'd0;
      done_q <= 1'b0;
      x1_q   <= 4'd0;
      x2_q   <= 4'd0;
      y_q    <= 4'd0;
    end else begin
      pe_q   <= issue;
      clr_q  <= issue && (pix == 8'd0);
      last_q <= issue && (pix == 8'hFF);
      tag_q  <= cand;
      done_q <= last_q;
      if (last_q) begin
        // Window offsets minus 8 give the signed displacement
        x1_q <= {tag_q[2:0], 1'b0} - 4'd8;
        x2_q <= {tag_q[2:0], 1'b1} - 4'd8;
        y_q  <= tag_q[6:3] - 4'd8;
      end
    end
  end

  // Search position = pixel position + candidate offset (even column pairs)
  assign row = {1'b0, pix[7:4]} + {1'b0, cand[6:3]};
  assign col = {1'b0, pix[3:0]} + {1'b0, cand[2:0], 1'b0};

  assign bus.address_ref       = issue ? pix : 8'd0;
  assign bus.address_search1   = issue ? {row, col} : 10'd0;
  assign bus.address_search2   = issue ? ({row, col} + 10'd1) : 10'd0;
  assign bus.pe_enable         = pe_q;
  assign bus.acc_clear         = clr_q;
  assign bus.cand_done         = done_q;
  assign bus.cand_x1           = x1_q;
  assign bus.cand_x2           = x2_q;
  assign bus.cand_y            = y_q;
  assign bus.process_completed = (state == DONE);
  assign bus.fsm_state         = state;

endmodule

// File: tb/tb_me_scheduler.sv
// Bench for me_scheduler: a reference SAD datapath with random memories,
// a per-pair scoreboard, a timing vector table and reset/start corner cases.
module tb_me_scheduler;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  me_scheduler_if bus ();

  me_scheduler dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Memories and two-accumulator SAD datapath fed by the sequencer
  logic [7:0]  ref_mem  [256];
  logic [7:0]  srch_mem [1024];
  logic [7:0]  ref_data;
  logic [7:0]  sd1;
  logic [7:0]  sd2;
  logic [15:0] acc1;
  logic [15:0] acc2;

  function automatic logic [15:0] absd(input logic [7:0] a, input logic [7:0] b);
    return (a > b) ? {8'd0, a - b} : {8'd0, b - a};
  endfunction

  // Registered memory reads and accumulate/load on pe_enable
  always @(posedge clk) begin
    ref_data <= ref_mem[bus.address_ref];
    sd1      <= srch_mem[bus.address_search1];
    sd2      <= srch_mem[bus.address_search2];
    if (bus.pe_enable) begin
      acc1 <= bus.acc_clear ? absd(ref_data, sd1) : acc1 + absd(ref_data, sd1);
      acc2 <= bus.acc_clear ? absd(ref_data, sd2) : acc2 + absd(ref_data, sd2);
    end
  end

  // Scoreboard entry: {dx1, dx2, dy, sad1, sad2}
  logic [43:0] exp_q[$];

  typedef struct {
    int         off;
    logic [7:0] aref;
    logic [9:0] s1;
    logic [9:0] s2;
    logic       pe;
    logic       clr;
    logic       done;
    logic       pc;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, req);
  endtask

  // Independent model: SAD of both candidates of pair c over the whole block
  task automatic push_expected();
    for (int c = 0; c < 128; c++) begin
      int          dy;
      int          dxo;
      logic [15:0] sad1;
      logic [15:0] sad2;
      logic [3:0]  x1;
      logic [3:0]  x2;
      logic [3:0]  y4;
      dy   = c / 8;
      dxo  = (c % 8) * 2;
      sad1 = 16'd0;
      sad2 = 16'd0;
      for (int y = 0; y < 16; y++) begin
        for (int x = 0; x < 16; x++) begin
          sad1 = sad1 + absd(ref_mem[y*16 + x], srch_mem[(y + dy)*32 + x + dxo]);
          sad2 = sad2 + absd(ref_mem[y*16 + x], srch_mem[(y + dy)*32 + x + dxo + 1]);
        end
      end
      x1 = 4'(dxo - 8);
      x2 = 4'(dxo - 7);
      y4 = 4'(dy - 8);
      exp_q.push_back({x1, x2, y4, sad1, sad2});
    end
  endtask

  // Full run from a fresh start edge; optional start glitch mid-run
  task automatic do_run(input bit toggle, input string tag);
    int          vi;
    int          dones;
    int          pe_cnt;
    int          pc_cyc;
    logic [43:0] req;
    vi     = 0;
    dones  = 0;
    pe_cnt = 0;
    pc_cyc = -1;
    exp_q.delete();
    push_expected();
    @(negedge clk);
    bus.start_signal = 1'b1;
    @(posedge clk);
    for (int cyc = 0; cyc <= 32775; cyc++) begin
      #1;
      if (vi < NV && vecs[vi].off == cyc) begin
        check($sformatf("%s_vec@%0d", tag, cyc),
              {32'd0, bus.address_ref, bus.address_search1, bus.address_search2,
               bus.pe_enable, bus.acc_clear, bus.cand_done, bus.process_completed},
              {32'd0, vecs[vi].aref, vecs[vi].s1, vecs[vi].s2,
               vecs[vi].pe, vecs[vi].clr, vecs[vi].done, vecs[vi].pc});
        vi++;
      end
      if (cyc == 0) check($sformatf("%s_state_run", tag), {62'd0, bus.fsm_state}, 64'd1);
      if (bus.pe_enable) pe_cnt++;
      if (bus.cand_done) begin
        dones++;
        if (exp_q.size() == 0) begin
          check($sformatf("%s_extra_done@%0d", tag, cyc), 64'd1, 64'd0);
        end else begin
          req = exp_q.pop_front();
          check($sformatf("%s_pair%0d", tag, dones - 1),
                {20'd0, bus.cand_x1, bus.cand_x2, bus.cand_y, acc1, acc2}, {20'd0, req});
        end
      end
      if (bus.process_completed && pc_cyc < 0) pc_cyc = cyc;
      if (toggle && cyc == 5000) bus.start_signal = 1'b0;
      if (toggle && cyc == 5003) bus.start_signal = 1'b1;
      @(posedge clk);
    end
    check($sformatf("%s_done_count", tag), 64'(dones), 64'd128);
    check($sformatf("%s_pe_count", tag), 64'(pe_cnt), 64'd32768);
    check($sformatf("%s_pc_cycle", tag), 64'(pc_cyc), 64'd32770);
    check($sformatf("%s_queue_left", tag), 64'(exp_q.size()), 64'd0);
    #1;
    bus.start_signal = 1'b0;
    @(posedge clk);
    #1;
    check($sformatf("%s_pc_drop", tag), {63'd0, bus.process_completed}, 64'd0);
    check($sformatf("%s_state_idle", tag), {62'd0, bus.fsm_state}, 64'd0);
  endtask

  task automatic check_all_zero(input string name);
    check(name,
          {25'd0, bus.address_ref, bus.address_search1, bus.address_search2,
           bus.pe_enable, bus.acc_clear, bus.cand_done,
           bus.cand_x1, bus.cand_x2, bus.cand_y, bus.process_completed},
          64'd0);
    check({name, "_state"}, {62'd0, bus.fsm_state}, 64'd0);
  endtask

  initial begin
    int dones;
    int pes;
    int busy;
    rst              = 1'b1;
    bus.start_signal = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 1024; i++) srch_mem[i] = 8'($urandom_range(0, 255));

    // Offsets are cycles after the start edge; addresses follow
    // row = y + cand/8, col = x + 2*(cand%8)
    vecs[0]  = '{0,     8'd0,   10'd0,     10'd1,     1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1,     8'd1,   10'd1,     10'd2,     1'b1, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{2,     8'd2,   10'd2,     10'd3,     1'b1, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{255,   8'd255, 10'h1EF,   10'h1F0,   1'b1, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{256,   8'd0,   10'd2,     10'd3,     1'b1, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{257,   8'd1,   10'd3,     10'd4,     1'b1, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{258,   8'd2,   10'd4,     10'd5,     1'b1, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{2049,  8'd1,   10'd33,    10'd34,    1'b1, 1'b1, 1'b1, 1'b0};
    vecs[8]  = '{2303,  8'd255, 10'h20F,   10'h210,   1'b1, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{2304,  8'd0,   10'h022,   10'h023,   1'b1, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{2305,  8'd1,   10'h023,   10'h024,   1'b1, 1'b1, 1'b1, 1'b0};
    vecs[11] = '{32767, 8'd255, 10'd989,   10'd990,   1'b1, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{32768, 8'd0,   10'd0,     10'd0,     1'b1, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{32769, 8'd0,   10'd0,     10'd0,     1'b0, 1'b0, 1'b1, 1'b0};
    vecs[14] = '{32770, 8'd0,   10'd0,     10'd0,     1'b0, 1'b0, 1'b0, 1'b1};
    vecs[15] = '{32775, 8'd0,   10'd0,     10'd0,     1'b0, 1'b0, 1'b0, 1'b1};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;

    // Run with a start glitch mid-run, then an identical second run
    do_run(1'b1, "run1");
    do_run(1'b0, "run2");

    // Reset 1000 cycles into a run
    @(negedge clk);
    bus.start_signal = 1'b1;
    @(posedge clk);
    repeat (999) @(posedge clk);
    #1;
    rst              = 1'b1;
    bus.start_signal = 1'b0;
    @(posedge clk);
    #1;
    check_all_zero("midrun_rst");
    rst   = 1'b0;
    dones = 0;
    pes   = 0;
    repeat (600) begin
      @(posedge clk);
      #1;
      if (bus.cand_done) dones++;
      if (bus.pe_enable) pes++;
    end
    check("midrun_no_done", 64'(dones), 64'd0);
    check("midrun_no_pe", 64'(pes), 64'd0);

    // Reset coincident with a start edge
    @(negedge clk);
    rst              = 1'b1;
    bus.start_signal = 1'b1;
    @(posedge clk);
    #1;
    rst              = 1'b0;
    bus.start_signal = 1'b0;
    check("coincident_state", {62'd0, bus.fsm_state}, 64'd0);
    busy = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (bus.fsm_state != 2'd0 || bus.pe_enable) busy++;
    end
    check("coincident_idle", 64'(busy), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
